// File: rtl/grey_pixel_packer_pkg.sv
// Shared widths and helpers for the greyscale pixel packer (package grey_pkg).
// Optional statistics outputs are enabled by defining GREY_PACK_STATS_EN.
package grey_pkg;

    localparam int GREY_PIX_W        = 8;
    localparam int GREY_WORD_W       = 32;
    localparam int GREY_PIX_PER_WORD = 4;
    localparam int GREY_CNT_W        = $clog2(GREY_PIX_PER_WORD);

    // Closes a word: three buffered lanes plus the pixel arriving in the last lane.
    function automatic logic [GREY_WORD_W-1:0] grey_assemble(
        input logic [GREY_WORD_W-GREY_PIX_W-1:0] acc,
        input logic [GREY_PIX_W-1:0]             last
    );
        return {last, acc};
    endfunction

endpackage

// File: rtl/grey_pixel_packer_if.sv
// Word stream between the pixel packer and its word FIFO.
// The packer drives pushes and pop requests; the FIFO returns its head, level and drop strobe.
interface grey_word_if
    import grey_pkg::*;
#(
    parameter int LVL_W = 4
) ();

    logic                   push;
    logic [GREY_WORD_W-1:0] push_data;
    logic                   pop_req;
    logic [GREY_WORD_W-1:0] head_data;
    logic                   head_valid;
    logic [LVL_W-1:0]       level;
    logic                   drop;

    modport master (
        output push, push_data, pop_req,
        input  head_data, head_valid, level, drop
    );

    modport slave (
        input  push, push_data, pop_req,
        output head_data, head_valid, level, drop
    );

endinterface

// File: rtl/grey_pixel_packer_fifo.sv
// First-word fall-through word FIFO with registered head and occupancy level.
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module grey_word_fifo
    import grey_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    grey_word_if.slave fifo
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [GREY_WORD_W-1:0] mem_q [DEPTH];
    logic [GREY_WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       cnt_q, cnt_d;
    logic [GREY_WORD_W-1:0] head_q, head_d;
    logic                   hval_q, hval_d;
    logic                   pop_s, full_s, push_ok_s, drop_s;

    // Next-state: storage, pointers, level, and the head value seen after this edge.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        pop_s     = fifo.pop_req && (cnt_q != LVL_W'(0));
        full_s    = (cnt_q == LVL_W'(DEPTH));
        push_ok_s = fifo.push && (!full_s || pop_s);
        drop_s    = fifo.push && full_s && !pop_s;

        if (push_ok_s) begin
            mem_d[wr_ptr_q] = fifo.push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   cnt_d = cnt_q + LVL_W'(1);
            2'b01:   cnt_d = cnt_q - LVL_W'(1);
            default: cnt_d = cnt_q;
        endcase

        hval_d = (cnt_d != LVL_W'(0));
        if (hval_d) begin
            head_d = mem_d[rd_ptr_d];
        end else begin
            head_d = {GREY_WORD_W{1'b0}};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {GREY_WORD_W{1'b0}};
            end
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            cnt_q    <= LVL_W'(0);
            head_q   <= {GREY_WORD_W{1'b0}};
            hval_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            hval_q   <= hval_d;
        end
    end

    assign fifo.head_data  = head_q;
    assign fifo.head_valid = hval_q;
    assign fifo.level      = cnt_q;
    assign fifo.drop       = drop_s;

endmodule

// File: rtl/grey_pixel_packer.sv
// Packs 8-bit greyscale pixels little-endian into 32-bit words buffered in a FWFT FIFO.
// Defining GREY_PACK_STATS_EN adds per-frame word count and dropped-word count outputs.
module grey_pixel_packer
    import grey_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [GREY_PIX_W-1:0]  iLum,
    input  logic                   iDVAL,
    input  logic                   iSOF,
    output logic [GREY_WORD_W-1:0] oWORD,
    output logic                   oWVAL,
    input  logic                   iWREADY,
    output logic [LVL_W-1:0]       oLEVEL,
    output logic                   oOVF
`ifdef GREY_PACK_STATS_EN
    ,
    output logic [15:0]            oFRAME_WORDS,
    output logic [7:0]             oDROP_CNT
`endif
);

    localparam int ACC_W = GREY_WORD_W - GREY_PIX_W;

    grey_word_if #(.LVL_W(LVL_W)) u_bus ();

    logic [GREY_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic [GREY_CNT_W-1:0] lane_s;
    logic                  push_s;

    // Byte lane steering; a start-of-frame forces the current pixel into lane 0.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        push_s     = 1'b0;
        lane_s     = iSOF ? GREY_CNT_W'(0) : byte_cnt_q;

        if (iDVAL) begin
            case (lane_s)
                2'd0:    acc_d[7:0]   = iLum;
                2'd1:    acc_d[15:8]  = iLum;
                2'd2:    acc_d[23:16] = iLum;
                2'd3:    push_s       = 1'b1;
                default: acc_d        = acc_q;
            endcase
            byte_cnt_d = lane_s + GREY_CNT_W'(1);
        end else if (iSOF) begin
            byte_cnt_d = GREY_CNT_W'(0);
        end else begin
            byte_cnt_d = byte_cnt_q;
        end

        ovf_d = ovf_q | u_bus.drop;
    end

    // Packer state registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            byte_cnt_q <= GREY_CNT_W'(0);
            acc_q      <= ACC_W'(0);
            ovf_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign u_bus.push      = push_s;
    assign u_bus.push_data = grey_assemble(acc_q, iLum);
    assign u_bus.pop_req   = oWVAL & iWREADY;

    grey_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk  (iCLK),
        .rst  (iRST),
        .fifo (u_bus.slave)
    );

    assign oWORD  = u_bus.head_data;
    assign oWVAL  = u_bus.head_valid;
    assign oLEVEL = u_bus.level;
    assign oOVF   = ovf_q;

`ifdef GREY_PACK_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] frame_words_q, frame_words_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        accepted_s;

    // Accepted pushes are counted per frame; drops saturate at 255.
    always_comb begin
        accepted_s    = push_s && !u_bus.drop;
        frame_words_d = frame_words_q;
        frame_cnt_d   = frame_cnt_q;
        drop_cnt_d    = drop_cnt_q;

        if (iSOF) begin
            frame_words_d = frame_cnt_q;
            frame_cnt_d   = accepted_s ? 16'd1 : 16'd0;
        end else if (accepted_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        if (u_bus.drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            frame_cnt_q   <= 16'd0;
            frame_words_q <= 16'd0;
            drop_cnt_q    <= 8'd0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            frame_words_q <= frame_words_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign oFRAME_WORDS = frame_words_q;
    assign oDROP_CNT    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_grey_pixel_packer.sv
// Directed bench for grey_pixel_packer: a per-cycle vector table plus hand-written
// sequences for overflow, full-with-pop, reset mid-burst and (with GREY_PACK_STATS_EN) stats.
module tb_grey_pixel_packer;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [7:0]  iLum = 8'h00;
    logic        iDVAL = 1'b0;
    logic        iSOF = 1'b0;
    logic        iWREADY = 1'b0;
    logic [31:0] oWORD;
    logic        oWVAL;
    logic [3:0]  oLEVEL;
    logic        oOVF;
`ifdef GREY_PACK_STATS_EN
    logic [15:0] oFRAME_WORDS;
    logic [7:0]  oDROP_CNT;
`endif

    int errors = 0;
    int checks = 0;

    grey_pixel_packer #(.FIFO_DEPTH(8), .LVL_W(4)) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iLum    (iLum),
        .iDVAL   (iDVAL),
        .iSOF    (iSOF),
        .oWORD   (oWORD),
        .oWVAL   (oWVAL),
        .iWREADY (iWREADY),
        .oLEVEL  (oLEVEL),
        .oOVF    (oOVF)
`ifdef GREY_PACK_STATS_EN
        ,
        .oFRAME_WORDS (oFRAME_WORDS),
        .oDROP_CNT    (oDROP_CNT)
`endif
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        dval;
        logic        sof;
        logic [7:0]  lum;
        logic        wready;
        logic        exp_wval;
        logic [31:0] exp_word;
        logic [3:0]  exp_lvl;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic dval, input logic sof, input logic [7:0] lum, input logic wready);
        iDVAL   = dval;
        iSOF    = sof;
        iLum    = lum;
        iWREADY = wready;
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [31:0] mkw(input int k);
        logic [7:0] b;
        b = 8'(k * 16);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic push_word(input int k, input logic wr_last);
        logic [31:0] w;
        w = mkw(k);
        step(1'b1, 1'b0, w[7:0],   1'b0);
        step(1'b1, 1'b0, w[15:8],  1'b0);
        step(1'b1, 1'b0, w[23:16], 1'b0);
        step(1'b1, 1'b0, w[31:24], wr_last);
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_wval",  {31'd0, oWVAL}, 32'd0);
        check("rst_level", {28'd0, oLEVEL}, 32'd0);
        check("rst_ovf",   {31'd0, oOVF}, 32'd0);
        check("rst_word",  oWORD, 32'd0);
`ifdef GREY_PACK_STATS_EN
        check("rst_frame_words", {16'd0, oFRAME_WORDS}, 32'd0);
        check("rst_drop_cnt",    {24'd0, oDROP_CNT}, 32'd0);
`endif
        iRST = 1'b0;
    endtask

    initial begin
        //            dval  sof   lum    wrdy  wval  word          lvl
        vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[3]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[4]  = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 32'h44332211, 4'd1};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[6]  = '{1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[7]  = '{1'b1, 1'b0, 8'hBB, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[8]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[9]  = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[10] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[11] = '{1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 32'h04030201, 4'd1};
        vecs[12] = '{1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[14] = '{1'b1, 1'b0, 8'h06, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[15] = '{1'b1, 1'b0, 8'h07, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[16] = '{1'b1, 1'b0, 8'h08, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[17] = '{1'b1, 1'b0, 8'h09, 1'b1, 1'b1, 32'h09080706, 4'd1};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        4'd0};

        do_reset();

        // Basic packing, sparse valid, start-of-frame discard and realignment.
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].dval, vecs[i].sof, vecs[i].lum, vecs[i].wready);
            check($sformatf("vec%0d_wval", i),  {31'd0, oWVAL}, {31'd0, vecs[i].exp_wval});
            check($sformatf("vec%0d_level", i), {28'd0, oLEVEL}, {28'd0, vecs[i].exp_lvl});
            if (vecs[i].exp_wval) begin
                check($sformatf("vec%0d_word", i), oWORD, vecs[i].exp_word);
            end
        end

        // Overflow: nine words into a depth-8 FIFO with the consumer stalled.
        do_reset();
        for (int k = 0; k < 8; k++) push_word(k, 1'b0);
        check("ovf_level8", {28'd0, oLEVEL}, 32'd8);
        check("ovf_flag_pre", {31'd0, oOVF}, 32'd0);
        push_word(8, 1'b0);
        check("ovf_level_after", {28'd0, oLEVEL}, 32'd8);
        check("ovf_flag", {31'd0, oOVF}, 32'd1);
        check("ovf_head_stable", oWORD, mkw(0));
`ifdef GREY_PACK_STATS_EN
        check("ovf_drop_cnt", {24'd0, oDROP_CNT}, 32'd1);
`endif
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf_drain_wval%0d", k), {31'd0, oWVAL}, 32'd1);
            check($sformatf("ovf_drain_word%0d", k), oWORD, mkw(k));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("ovf_drained_wval", {31'd0, oWVAL}, 32'd0);
        check("ovf_sticky", {31'd0, oOVF}, 32'd1);

        // Full FIFO with a pop on the completing cycle keeps all words.
        do_reset();
        for (int k = 0; k < 8; k++) push_word(k, 1'b0);
        push_word(8, 1'b1);
        check("fullpop_level", {28'd0, oLEVEL}, 32'd8);
        check("fullpop_ovf", {31'd0, oOVF}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("fullpop_word%0d", k), oWORD, mkw(k));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("fullpop_empty", {28'd0, oLEVEL}, 32'd0);
        check("fullpop_ovf_end", {31'd0, oOVF}, 32'd0);

        // Reset with three buffered words and a partial word.
        do_reset();
        for (int k = 0; k < 3; k++) push_word(k, 1'b0);
        step(1'b1, 1'b0, 8'h61, 1'b0);
        step(1'b1, 1'b0, 8'h62, 1'b0);
        check("midrst_level_pre", {28'd0, oLEVEL}, 32'd3);
        iRST = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("midrst_wval", {31'd0, oWVAL}, 32'd0);
        check("midrst_level", {28'd0, oLEVEL}, 32'd0);
        iRST = 1'b0;
        step(1'b1, 1'b0, 8'h51, 1'b1);
        step(1'b1, 1'b0, 8'h52, 1'b1);
        step(1'b1, 1'b0, 8'h53, 1'b1);
        check("midrst_no_early", {31'd0, oWVAL}, 32'd0);
        step(1'b1, 1'b0, 8'h54, 1'b1);
        check("midrst_wval_post", {31'd0, oWVAL}, 32'd1);
        check("midrst_word", oWORD, 32'h54535251);
        check("midrst_level_post", {28'd0, oLEVEL}, 32'd1);

`ifdef GREY_PACK_STATS_EN
        // Forty pixels between two start-of-frame pulses make ten words.
        do_reset();
        step(1'b0, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("stats_frame_words", {16'd0, oFRAME_WORDS}, 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grey_pixel_packer.md
GREY_PIXEL_PACKER -- requirements
Module: grey_pixel_packer

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 8, meaning the word FIFO depth (power of two, 4..64).
REQ-002 The module SHALL have parameter LVL_W, default 4, meaning the oLEVEL width, equal to $clog2(FIFO_DEPTH)+1.
REQ-003 The module SHALL have port iCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port iRST, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port iLum, input, 8 bits: greyscale pixel from the demosaic/luma stage.
REQ-006 The module SHALL have port iDVAL, input, 1 bit: iLum valid qualifier, sparse (at most 1 in 2 cycles is not guaranteed, so any pattern is legal).
REQ-007 The module SHALL have port iSOF, input, 1 bit: single-cycle start-of-frame pulse.
REQ-008 The module SHALL have port oWORD, output, 32 bits: packed word at the FIFO head.
REQ-009 The module SHALL have port oWVAL, output, 1 bit: oWORD valid (FIFO not empty).
REQ-010 The module SHALL have port iWREADY, input, 1 bit: consumer ready; a word transfers when oWVAL & iWREADY.
REQ-011 The module SHALL have port oLEVEL, output, LVL_W bits: FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 The module SHALL have port oOVF, output, 1 bit: sticky overflow flag.

Function
REQ-013 Pixels SHALL be packed little-endian: 1st accepted pixel in oWORD[7:0], then [15:8], [23:16], and the 4th in [31:24].
REQ-014 A 2-bit byte counter SHALL advance on each iDVAL and wrap 3->0; on the 4th byte the completed word SHALL be pushed into the FIFO in that same cycle.
REQ-015 Latency SHALL be: oWVAL is asserted with the new word the cycle after the 4th iDVAL, provided the FIFO was empty (first-word fall-through, registered).
REQ-016 oWORD/oWVAL SHALL stay stable while oWVAL=1 and iWREADY=0.
REQ-017 On iSOF, the byte counter SHALL be cleared and any partial word discarded; FIFO contents SHALL be retained.
REQ-018 If iSOF and iDVAL coincide, that pixel SHALL become byte 0 of the new frame.
REQ-019 If a word completes while the FIFO is full and no pop occurs that cycle, the word SHALL be dropped and oOVF set; FIFO contents SHALL be unchanged.
REQ-020 If a word completes while the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted and oLEVEL SHALL stay at FIFO_DEPTH.
REQ-021 Simultaneous push and pop at any level SHALL leave oLEVEL unchanged.
REQ-022 oOVF SHALL be sticky and cleared only by iRST.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 While iRST=1: oWVAL=0, oLEVEL=0, oOVF=0, the byte counter=0, the pointers=0, and oWORD=0.
REQ-025 iRST asserted mid-word or mid-burst SHALL discard all partial and buffered data; the first iDVAL after release SHALL be byte 0.

Configuration
REQ-026 The macro GREY_PACK_STATS_EN SHALL, when defined, add outputs oFRAME_WORDS[15:0] and oDROP_CNT[7:0].
REQ-027 With GREY_PACK_STATS_EN defined, oFRAME_WORDS SHALL latch, on iSOF, the count of words pushed since the previous iSOF, then restart the count.
REQ-028 With GREY_PACK_STATS_EN defined, oDROP_CNT SHALL count dropped words, saturate at 255, and clear only on iRST.
REQ-029 With GREY_PACK_STATS_EN defined, both stats outputs SHALL be 0 in reset.
REQ-030 With GREY_PACK_STATS_EN undefined, the ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-031 Package grey_pkg SHALL hold GREY_PIX_W=8, GREY_WORD_W=32, and GREY_PIX_PER_WORD=4.
REQ-032 The FIFO SHALL be one sub-module, grey_word_fifo (parameterised depth, FWFT, with level output), instantiated once.

Verification
REQ-033 The bench SHALL drive reset then iDVAL with iLum 0x11,0x22,0x33,0x44 and iWREADY=1, and SHALL see oWORD=0x44332211 with oWVAL high exactly one cycle after the 4th pixel.
REQ-034 The bench SHALL drive pixels 0xAA,0xBB, then iSOF with iDVAL and 0x01, then 0x02,0x03,0x04, and SHALL see only 0x04030201 emitted, with no word containing 0xAA.
REQ-035 The bench SHALL hold iWREADY=0 and push 9 words with FIFO_DEPTH=8, and SHALL see oLEVEL=8, oOVF=1, and the 9th word absent on drain (oDROP_CNT=1 with stats).
REQ-036 The bench SHALL fill the FIFO to 8, then complete a word on the same cycle as iWREADY=1, and SHALL see oLEVEL stay 8, oOVF=0, and all words drain in order.
REQ-037 The bench SHALL assert iRST after 2 bytes and 3 buffered words, and SHALL see oWVAL=0 and oLEVEL=0 next cycle, with the next 4 pixels forming the first word.
REQ-038 With GREY_PACK_STATS_EN, the bench SHALL drive 40 pixels between two iSOF pulses, and SHALL see oFRAME_WORDS=10 after the second iSOF.
